// File: rtl/logic_engine_bridge_if.sv
// rtl/logic_engine_bridge_if.sv - CPU req/ack and engine valid/ready signals of the logic-engine bridge
// master is the bridge side; slave is the CPU/engine environment side.
interface logic_engine_bridge_if;
    logic        logic_req;
    logic [31:0] logic_addr;
    logic        logic_ack;
    logic [31:0] logic_data;
    logic        eng_req_valid;
    logic        eng_req_ready;
    logic [31:0] eng_req_addr;
    logic        eng_rsp_valid;
    logic        eng_rsp_ready;
    logic [31:0] eng_rsp_data;
    logic        eng_rsp_err;

    modport master (
        input  logic_req, logic_addr, eng_req_ready, eng_rsp_valid, eng_rsp_data, eng_rsp_err,
        output logic_ack, logic_data, eng_req_valid, eng_req_addr, eng_rsp_ready
    );

    modport slave (
        output logic_req, logic_addr, eng_req_ready, eng_rsp_valid, eng_rsp_data, eng_rsp_err,
        input  logic_ack, logic_data, eng_req_valid, eng_req_addr, eng_rsp_ready
    );
endinterface

// File: rtl/logic_engine_bridge.sv
// rtl/logic_engine_bridge.sv - CPU req/ack to engine valid/ready bridge with timeout and counters
// Late or unsolicited engine responses are drained and counted rather than delivered.
module logic_engine_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD0001,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    logic_engine_bridge_if.master     bus,
    output logic                      busy,
    output logic                      err_sticky,
    output logic [CNT_W-1:0]          txn_count,
    output logic [CNT_W-1:0]          timeout_count,
    output logic [CNT_W-1:0]          stale_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_ACK,
        S_RELEASE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] stale_q, stale_d;

    logic rsp_ready;
    logic rsp_hs;
    logic in_flight;
    logic timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign rsp_ready   = (state_q != S_ACK);
    assign rsp_hs      = bus.eng_rsp_valid & rsp_ready;
    assign in_flight   = (state_q == S_ISSUE) || (state_q == S_WAIT_RSP);
    // A response landing in the last allowed cycle beats the timeout.
    assign timeout_hit = in_flight && (tmo_q == TMO_LAST) &&
                         !((state_q == S_WAIT_RSP) && rsp_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.logic_req) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (timeout_hit)            state_d = S_ACK;
                else if (bus.eng_req_ready) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (rsp_hs || timeout_hit) state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.logic_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.logic_ack     = (state_q == S_ACK);
        bus.eng_req_valid = (state_q == S_ISSUE);
        bus.eng_rsp_ready = rsp_ready;
        busy              = (state_q != S_IDLE);
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        txn_d   = txn_q;
        tcnt_d  = tcnt_q;
        stale_d = stale_q;

        if ((state_q == S_IDLE) && bus.logic_req) begin
            addr_d = bus.logic_addr;
            tmo_d  = 16'd0;
        end
        if (in_flight) begin
            tmo_d = tmo_q + 16'd1;
        end
        if ((state_q == S_WAIT_RSP) && rsp_hs) begin
            data_d = bus.eng_rsp_data;
            if (bus.eng_rsp_err) err_d = 1'b1;
        end
        if (timeout_hit) begin
            data_d = TIMEOUT_DATA;
            err_d  = 1'b1;
            tcnt_d = sat_inc(tcnt_q);
        end
        if (state_q == S_ACK) begin
            txn_d = sat_inc(txn_q);
        end
        // Anything handshaken outside WAIT_RSP has no transaction to belong to.
        if (rsp_hs && (state_q != S_WAIT_RSP)) begin
            stale_d = sat_inc(stale_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            txn_q   <= '0;
            tcnt_q  <= '0;
            stale_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
            tcnt_q  <= tcnt_d;
            stale_q <= stale_d;
        end
    end

    assign bus.logic_data   = data_q;
    assign bus.eng_req_addr = addr_q;
    assign err_sticky       = err_q;
    assign txn_count        = txn_q;
    assign timeout_count    = tcnt_q;
    assign stale_count      = stale_q;

endmodule
